// File: rtl/uart_rx_fifo.sv
// uart_rx_fifo
//   UART receiver for 8-bit frames with a receive FIFO behind it.
//   Frame format is 8N1 by default. With the macro UART_RX_PARITY_EN defined,
//   the frame is 8E1: an even-parity bit follows the data bits.
//
// Parameters
//   CLK_FREQ_HZ  core clock frequency in Hz
//   BAUD         line rate; one bit lasts DIV = CLK_FREQ_HZ/BAUD clocks (truncated)
//   FIFO_DEPTH   receive FIFO entries, power of two, 2..64
//
// Ports
//   clk           core clock, rising edge
//   rstn          asynchronous active-low reset
//   i_uart_rx     serial line, idle high, asynchronous to clk
//   o_data        byte at the FIFO head
//   o_valid       FIFO non-empty
//   i_ready       consumer accept; a pop happens when o_valid && i_ready
//   o_count       FIFO occupancy
//   o_frame_err   one-cycle pulse, stop bit sampled low
//   o_parity_err  one-cycle pulse, parity mismatch (tied 0 without parity)
//   o_overrun     sticky, a received byte was dropped because the FIFO was full
//   i_clr         synchronous clear of o_overrun (a new overrun wins)
module uart_rx_fifo #(
   parameter int unsigned CLK_FREQ_HZ = 12_500_000,
   parameter int unsigned BAUD        = 115200,
   parameter int unsigned FIFO_DEPTH  = 8
) (
   input  logic                        clk,
   input  logic                        rstn,
   input  logic                        i_uart_rx,
   output logic [7:0]                  o_data,
   output logic                        o_valid,
   input  logic                        i_ready,
   output logic [$clog2(FIFO_DEPTH):0] o_count,
   output logic                        o_frame_err,
   output logic                        o_parity_err,
   output logic                        o_overrun,
   input  logic                        i_clr
);

   localparam int unsigned DIV   = CLK_FREQ_HZ / BAUD;
   localparam int unsigned HALF  = DIV / 2;
   localparam int unsigned CNT_W = $clog2(DIV + 1);
   localparam int unsigned AW    = $clog2(FIFO_DEPTH);
   localparam int unsigned CW    = AW + 1;

   localparam logic [2:0] S_IDLE   = 3'd0;
   localparam logic [2:0] S_START  = 3'd1;
   localparam logic [2:0] S_DATA   = 3'd2;
`ifdef UART_RX_PARITY_EN
   localparam logic [2:0] S_PARITY = 3'd3;
`endif
   localparam logic [2:0] S_STOP   = 3'd4;

   // ------------------------------------------------------------------
   // Line synchronizer plus one history flop for falling-edge detection
   // ------------------------------------------------------------------
   logic rx_meta_q;
   logic rx_s_q;
   logic rx_prev_q;

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         rx_meta_q <= 1'b1;
         rx_s_q    <= 1'b1;
         rx_prev_q <= 1'b1;
      end else begin
         rx_meta_q <= i_uart_rx;
         rx_s_q    <= rx_meta_q;
         rx_prev_q <= rx_s_q;
      end
   end

   // ------------------------------------------------------------------
   // Receive FSM
   // ------------------------------------------------------------------
   logic [2:0]       state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [2:0]       bit_idx_q, bit_idx_d;
   logic [7:0]       shift_q, shift_d;
   logic             frame_err_q, frame_err_d;
   logic             expire_c;
   logic             push_c;
`ifdef UART_RX_PARITY_EN
   logic             par_q, par_d;
   logic             parity_err_q, parity_err_d;
   logic             par_bad_c;
`endif

   // State and datapath registers
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state_q      <= S_IDLE;
         cnt_q        <= '0;
         bit_idx_q    <= '0;
         shift_q      <= '0;
         frame_err_q  <= 1'b0;
`ifdef UART_RX_PARITY_EN
         par_q        <= 1'b0;
         parity_err_q <= 1'b0;
`endif
      end else begin
         state_q      <= state_d;
         cnt_q        <= cnt_d;
         bit_idx_q    <= bit_idx_d;
         shift_q      <= shift_d;
         frame_err_q  <= frame_err_d;
`ifdef UART_RX_PARITY_EN
         par_q        <= par_d;
         parity_err_q <= parity_err_d;
`endif
      end
   end

   // Next-state logic; the bit timer counts down and samples when it reads 1
   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      bit_idx_d   = bit_idx_q;
      shift_d     = shift_q;
      frame_err_d = 1'b0;
      push_c      = 1'b0;
      expire_c    = (cnt_q == CNT_W'(1));
`ifdef UART_RX_PARITY_EN
      par_d        = par_q;
      parity_err_d = 1'b0;
      par_bad_c    = (^shift_q) ^ par_q;
`endif

      case (state_q)
         S_IDLE: begin
            // Edge (not level) detect, so a held-low line cannot retrigger
            if (!rx_s_q && rx_prev_q) begin
               state_d = S_START;
               cnt_d   = CNT_W'(HALF);
            end
         end

         S_START: begin
            cnt_d = cnt_q - CNT_W'(1);
            if (expire_c) begin
               if (!rx_s_q) begin
                  state_d   = S_DATA;
                  cnt_d     = CNT_W'(DIV);
                  bit_idx_d = 3'd0;
               end else begin
                  state_d = S_IDLE;
               end
            end
         end

         S_DATA: begin
            cnt_d = cnt_q - CNT_W'(1);
            if (expire_c) begin
               shift_d   = {rx_s_q, shift_q[7:1]};
               cnt_d     = CNT_W'(DIV);
               bit_idx_d = bit_idx_q + 3'd1;
               if (bit_idx_q == 3'd7) begin
`ifdef UART_RX_PARITY_EN
                  state_d = S_PARITY;
`else
                  state_d = S_STOP;
`endif
               end
            end
         end

`ifdef UART_RX_PARITY_EN
         S_PARITY: begin
            cnt_d = cnt_q - CNT_W'(1);
            if (expire_c) begin
               par_d   = rx_s_q;
               cnt_d   = CNT_W'(DIV);
               state_d = S_STOP;
            end
         end
`endif

         S_STOP: begin
            cnt_d = cnt_q - CNT_W'(1);
            if (expire_c) begin
               state_d     = S_IDLE;
               frame_err_d = !rx_s_q;
`ifdef UART_RX_PARITY_EN
               parity_err_d = par_bad_c;
               push_c       = rx_s_q && !par_bad_c;
`else
               push_c       = rx_s_q;
`endif
            end
         end

         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   assign o_frame_err = frame_err_q;
`ifdef UART_RX_PARITY_EN
   assign o_parity_err = parity_err_q;
`else
   assign o_parity_err = 1'b0;
`endif

   // ------------------------------------------------------------------
   // Receive FIFO
   // ------------------------------------------------------------------
   logic [7:0]    mem_q [FIFO_DEPTH];
   logic [AW-1:0] wr_ptr_q, rd_ptr_q;
   logic [CW-1:0] count_q;
   logic          valid_q;
   logic [7:0]    data_q;
   logic          overrun_q;

   logic          pop_c, full_c, push_acc_c, drop_c;
   logic [AW-1:0] rd_next_c;
   logic [CW-1:0] count_next_c;
   logic [7:0]    head_next_c;

   // Pointer/occupancy update and the byte that becomes the registered head
   always_comb begin
      pop_c      = valid_q && i_ready;
      full_c     = (count_q == CW'(FIFO_DEPTH));
      push_acc_c = push_c && (!full_c || pop_c);
      drop_c     = push_c && full_c && !pop_c;
      rd_next_c  = rd_ptr_q + AW'(pop_c);

      count_next_c = count_q;
      if (push_acc_c && !pop_c) begin
         count_next_c = count_q + CW'(1);
      end else if (!push_acc_c && pop_c) begin
         count_next_c = count_q - CW'(1);
      end

      // The slot being written this cycle is the new head only when the
      // FIFO would otherwise be empty; the memory read would be stale then.
      head_next_c = mem_q[rd_next_c];
      if (push_acc_c && (wr_ptr_q == rd_next_c)) begin
         head_next_c = shift_q;
      end
   end

   // Control registers and registered head byte
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         wr_ptr_q  <= '0;
         rd_ptr_q  <= '0;
         count_q   <= '0;
         valid_q   <= 1'b0;
         data_q    <= '0;
         overrun_q <= 1'b0;
      end else begin
         if (push_acc_c) begin
            wr_ptr_q <= wr_ptr_q + AW'(1);
         end
         rd_ptr_q <= rd_next_c;
         count_q  <= count_next_c;
         valid_q  <= (count_next_c != '0);
         if (count_next_c != '0) begin
            data_q <= head_next_c;
         end
         if (drop_c) begin
            overrun_q <= 1'b1;
         end else if (i_clr) begin
            overrun_q <= 1'b0;
         end
      end
   end

   // Storage array, no reset needed: the head register hides unwritten slots
   always_ff @(posedge clk) begin
      if (push_acc_c) begin
         mem_q[wr_ptr_q] <= shift_q;
      end
   end

   assign o_data    = data_q;
   assign o_valid   = valid_q;
   assign o_count   = count_q;
   assign o_overrun = overrun_q;

endmodule

// File: tb/tb_uart_rx_fifo.sv
// tb_uart_rx_fifo
//   Self-checking bench for uart_rx_fifo at default parameters. Frames are
//   driven bit by bit on the serial line; a queue-based model of the FIFO and
//   error counters gives the expected results. Parity frames are exercised
//   when UART_RX_PARITY_EN is defined.
`timescale 1ns/1ps
module tb_uart_rx_fifo;

   localparam int unsigned CLK_FREQ_HZ = 12_500_000;
   localparam int unsigned BAUD        = 115200;
   localparam int unsigned FIFO_DEPTH  = 8;
   localparam int          DIV         = int'(CLK_FREQ_HZ / BAUD);
`ifdef UART_RX_PARITY_EN
   localparam int NBITS  = 11;
   localparam bit PAR_EN = 1'b1;
`else
   localparam int NBITS  = 10;
   localparam bit PAR_EN = 1'b0;
`endif
   // Cycle (counted from the cycle the line falls) in which the stop bit is
   // sampled and the byte pushed: 2 sync cycles + DIV/2 + one DIV per later bit
   localparam int PUSH_CYC = 2 + DIV / 2 + (NBITS - 1) * DIV;

   logic                        clk;
   logic                        rstn;
   logic                        rx;
   logic                        rdy;
   logic                        clr;
   logic [7:0]                  o_data;
   logic                        o_valid;
   logic [$clog2(FIFO_DEPTH):0] o_count;
   logic                        o_frame_err;
   logic                        o_parity_err;
   logic                        o_overrun;

   uart_rx_fifo #(
      .CLK_FREQ_HZ (CLK_FREQ_HZ),
      .BAUD        (BAUD),
      .FIFO_DEPTH  (FIFO_DEPTH)
   ) dut (
      .clk          (clk),
      .rstn         (rstn),
      .i_uart_rx    (rx),
      .o_data       (o_data),
      .o_valid      (o_valid),
      .i_ready      (rdy),
      .o_count      (o_count),
      .o_frame_err  (o_frame_err),
      .o_parity_err (o_parity_err),
      .o_overrun    (o_overrun),
      .i_clr        (clr)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   // Pulse counters and o_valid rise time, sampled mid-cycle
   int   ferr_cnt   = 0;
   int   perr_cnt   = 0;
   int   last_rise  = -1;
   logic valid_prev = 1'b0;
   always @(negedge clk) begin
      if (o_frame_err)  ferr_cnt <= ferr_cnt + 1;
      if (o_parity_err) perr_cnt <= perr_cnt + 1;
      if (o_valid && !valid_prev) last_rise <= cyc;
      valid_prev <= o_valid;
   end

   // Reference model
   byte unsigned mq[$];
   bit           m_ovr    = 1'b0;
   int           exp_ferr = 0;
   int           exp_perr = 0;
   int           n_checks = 0;
   int           n_pass   = 0;
   int           frame_t0 = 0;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
   endtask

   function automatic bit epar(input byte unsigned d);
      return ^d;
   endfunction

   function automatic void model_frame(input byte unsigned d, input bit stop, input bit par);
      bit par_ok;
      par_ok = !PAR_EN || (par == epar(d));
      if (!stop)   exp_ferr++;
      if (!par_ok) exp_perr++;
      if (stop && par_ok) begin
         if (mq.size() < FIFO_DEPTH) mq.push_back(d);
         else m_ovr = 1'b1;
      end
   endfunction

   task automatic idle(input int n);
      repeat (n) @(negedge clk);
   endtask

   // Drives one frame; i_ready / i_clr are raised for exactly one cycle at
   // the given frame cycle (negative = never)
   task automatic send_frame(input byte unsigned d, input bit stop, input bit par,
                             input int rdy_at, input int clr_at);
      logic [NBITS-1:0] bits;
      bits[0]   = 1'b0;
      bits[8:1] = d;
      if (PAR_EN) bits[9] = par;
      bits[NBITS-1] = stop;
      frame_t0 = cyc;
      for (int k = 0; k < NBITS * DIV; k++) begin
         rx  = bits[k / DIV];
         rdy = (k == rdy_at);
         clr = (k == clr_at);
         @(negedge clk);
      end
      rx  = 1'b1;
      rdy = 1'b0;
      clr = 1'b0;
   endtask

   task automatic drain(input string tag);
      while (mq.size() > 0) begin
         check({tag, " valid"}, 32'(o_valid), 32'd1);
         check({tag, " data"}, 32'(o_data), 32'(mq[0]));
         rdy = 1'b1;
         @(negedge clk);
         rdy = 1'b0;
         void'(mq.pop_front());
      end
      check({tag, " empty"}, 32'(o_valid), 32'd0);
      check({tag, " count0"}, 32'(o_count), 32'd0);
   endtask

   task automatic check_state(input string tag);
      check({tag, " count"}, 32'(o_count), 32'(mq.size()));
      check({tag, " overrun"}, 32'(o_overrun), 32'(m_ovr));
      check({tag, " ferr"}, 32'(ferr_cnt), 32'(exp_ferr));
      check({tag, " perr"}, 32'(perr_cnt), 32'(exp_perr));
   endtask

   initial begin
      logic [9:0]   pf;
      byte unsigned d;
      bit           stop;
      bit           par;
      int           n;

      rx = 1'b1; rdy = 1'b0; clr = 1'b0; rstn = 1'b0;
      idle(3);
      check("rst valid", 32'(o_valid), 32'd0);
      check("rst count", 32'(o_count), 32'd0);
      check("rst data", 32'(o_data), 32'd0);
      check("rst ferr", 32'(o_frame_err), 32'd0);
      check("rst perr", 32'(o_parity_err), 32'd0);
      check("rst overrun", 32'(o_overrun), 32'd0);
      rstn = 1'b1;
      idle(DIV);

      // Single byte: exact latency from line fall to o_valid
      send_frame(8'h55, 1'b1, epar(8'h55), -1, -1);
      model_frame(8'h55, 1'b1, epar(8'h55));
      check("latency", 32'(last_rise - frame_t0), 32'(PUSH_CYC + 1));
      check("b55 count", 32'(o_count), 32'd1);
      check("b55 data", 32'(o_data), 32'h55);
      idle(DIV);
      drain("b55");

      // Stop bit low
      send_frame(8'hA3, 1'b0, epar(8'hA3), -1, -1);
      model_frame(8'hA3, 1'b0, epar(8'hA3));
      idle(DIV);
      check_state("ferr");
      check("ferr valid", 32'(o_valid), 32'd0);

      // Fill past full with the consumer stalled
      for (int i = 0; i < 9; i++) begin
         send_frame(byte'(i), 1'b1, epar(byte'(i)), -1, -1);
         model_frame(byte'(i), 1'b1, epar(byte'(i)));
         idle(DIV / 2);
      end
      check_state("ovr");
      check("ovr head", 32'(o_data), 32'h00);

      clr = 1'b1; idle(1); clr = 1'b0; m_ovr = 1'b0;
      check("clr overrun", 32'(o_overrun), 32'd0);

      // Clear in the same cycle as a new overrun: overrun stays set
      send_frame(8'h09, 1'b1, epar(8'h09), -1, PUSH_CYC);
      model_frame(8'h09, 1'b1, epar(8'h09));
      idle(DIV / 2);
      check_state("setwins");

      clr = 1'b1; idle(1); clr = 1'b0; m_ovr = 1'b0;

      // Push and pop in the same cycle while full: byte accepted
      send_frame(8'h0A, 1'b1, epar(8'h0A), PUSH_CYC, -1);
      void'(mq.pop_front());
      model_frame(8'h0A, 1'b1, epar(8'h0A));
      idle(DIV / 2);
      check_state("fullpp");
      check("fullpp head", 32'(o_data), 32'h01);
      drain("fullpp");

      // Short low glitch on an idle line
      rx = 1'b0; idle(DIV / 4); rx = 1'b1; idle(2 * DIV);
      check_state("glitch");
      send_frame(8'h81, 1'b1, epar(8'h81), -1, -1);
      model_frame(8'h81, 1'b1, epar(8'h81));
      idle(DIV);
      check_state("postglitch");
      drain("postglitch");

      // Break: one frame error only, then normal reception
      rx = 1'b0; idle(3 * NBITS * DIV); rx = 1'b1; idle(DIV);
      exp_ferr++;
      check_state("break");
      send_frame(8'h42, 1'b1, epar(8'h42), -1, -1);
      model_frame(8'h42, 1'b1, epar(8'h42));
      idle(DIV);
      check_state("postbreak");
      drain("postbreak");

      // Randomized bursts
      for (int b = 0; b < 3; b++) begin
         n = int'($urandom_range(1, 4));
         for (int i = 0; i < n; i++) begin
            d    = byte'($urandom);
            stop = ($urandom_range(0, 3) != 0);
            par  = epar(d);
            if (PAR_EN && stop && ($urandom_range(0, 3) == 0)) par = ~par;
            send_frame(d, stop, par, -1, -1);
            model_frame(d, stop, par);
            idle(DIV + int'($urandom_range(0, DIV / 2)));
         end
         check_state($sformatf("rand%0d", b));
         drain($sformatf("rand%0d", b));
      end

      // Reset in the middle of a frame, with a byte already queued
      send_frame(8'h5A, 1'b1, epar(8'h5A), -1, -1);
      model_frame(8'h5A, 1'b1, epar(8'h5A));
      idle(DIV);
      check("pre-rst count", 32'(o_count), 32'd1);
      pf = {1'b1, 8'h3C, 1'b0};
      for (int k = 0; k < 5 * DIV + DIV / 2; k++) begin
         rx = pf[k / DIV];
         @(negedge clk);
      end
      rstn = 1'b0; rx = 1'b1;
      idle(2);
      mq.delete(); m_ovr = 1'b0;
      check("midrst valid", 32'(o_valid), 32'd0);
      check("midrst count", 32'(o_count), 32'd0);
      check("midrst data", 32'(o_data), 32'd0);
      rstn = 1'b1;
      idle(DIV);
      send_frame(8'hC3, 1'b1, epar(8'hC3), -1, -1);
      model_frame(8'hC3, 1'b1, epar(8'hC3));
      idle(DIV);
      check_state("postrst");
      drain("postrst");

`ifdef UART_RX_PARITY_EN
      // Wrong parity then correct parity for the same byte
      send_frame(8'h07, 1'b1, 1'b0, -1, -1);
      model_frame(8'h07, 1'b1, 1'b0);
      idle(DIV);
      check_state("parbad");
      send_frame(8'h07, 1'b1, 1'b1, -1, -1);
      model_frame(8'h07, 1'b1, 1'b1);
      idle(DIV);
      check_state("pargood");
      drain("pargood");
`endif

      check_state("final");
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
